conv_seq_ctrl: RTL and testbench
================================

CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter IMG_PIXELS, default 144, meaning pixels streamed per pass (12x12 image).
REQ-002 SHALL have parameter OUT_COUNT, default 100, meaning results expected per pass.
REQ-003 SHALL have parameter TIMEOUT, default 1023, meaning maximum DRAIN cycles before abort.
REQ-004 SHALL have ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- start  in  1  one-cycle job request.
- num_passes  in  4  passes per job, valid 1..8; 0 is treated as 1, values >8 as 8.
- bias_wr_en  in  1  bias bank write strobe.
- bias_wr_idx  in  3  bias bank entry.
- bias_wr_data  in  32  bias value.
- img_rd_addr  out  8  image memory read address.
- img_rd_data  in  16  image memory data; synchronous read, 1-cycle latency.
- conv_reset  out  1  active-high reset to the conv engine.
- conv_valid  out  1  pixel-valid to the conv engine.
- conv_input_port  out  16  pixel to the conv engine.
- conv_bias  out  32  bias to the conv engine.
- conv_output_port  in  32  conv result.
- conv_invalid  in  1  low = conv_output_port holds a valid result.
- conv_finish  in  1  conv engine pass complete.
- res_wr_en  out  1  result memory write strobe.
- res_wr_addr  out  10  result address.
- res_wr_data  out  32  result data.
- busy  out  1  high from start acceptance to done.
- done  out  1  one-cycle job-complete pulse.
- error  out  1  sticky fault flag; cleared on the next accepted start.

Function
REQ-005 SHALL implement the FSM IDLE -> CLR -> PRIME -> STREAM -> DRAIN -> (CLR for the next pass | FIN) -> IDLE.
REQ-006 IDLE: start=1 SHALL be accepted, latching the pass count, setting pass=0 and busy=1, and clearing error; start outside IDLE SHALL be ignored.
REQ-007 CLR SHALL last exactly one cycle, with conv_reset=1 and the result counter cleared.
REQ-008 PRIME SHALL last one cycle, with img_rd_addr=0 and conv_valid=0.
REQ-009 STREAM SHALL last exactly IMG_PIXELS cycles.
- Cycle k (0-based): conv_valid=1, conv_input_port=img_rd_data (data of address k), img_rd_addr=k+1.
- conv_valid SHALL be contiguous, with no gaps.
REQ-010 conv_bias SHALL equal bias_bank[pass] from CLR through DRAIN; it SHALL be 0 otherwise.
REQ-011 Result capture:
- In STREAM or DRAIN, conv_invalid=0 and result counter < OUT_COUNT SHALL set res_wr_en=1 combinationally that cycle.
- res_wr_data SHALL equal conv_output_port.
- res_wr_addr SHALL equal pass*OUT_COUNT + counter; the counter then increments.
REQ-012 Results arriving with counter = OUT_COUNT SHALL be dropped and SHALL set error.
REQ-013 conv_finish=1 sampled in STREAM or DRAIN SHALL end the pass; any result in that same cycle SHALL still be captured first.
- If the counter after capture is not OUT_COUNT, error SHALL be set.
- conv_finish during STREAM SHALL set error.
REQ-014 After a pass ends, pass+1 < count SHALL go to CLR with pass incremented; otherwise the FSM SHALL go to FIN.
REQ-015 DRAIN SHALL count cycles; reaching TIMEOUT without conv_finish SHALL set error and go to FIN, skipping remaining passes.
REQ-016 FIN SHALL last one cycle, with done=1, then busy=0 in IDLE.
REQ-017 A bias write with bias_wr_en=1 SHALL update bias_bank[bias_wr_idx] only when busy=0; writes while busy SHALL be ignored.
REQ-018 Outside STREAM: conv_valid=0 and conv_input_port=0.
REQ-019 Outside capture cycles: res_wr_en=0, with res_wr_addr and res_wr_data holding their last value.

Reset
REQ-020 reset=0 at a clock edge SHALL force the following, regardless of state, including mid-STREAM:
- FSM to IDLE.
- conv_reset=1 while reset=0.
- All bias entries to 0.
- All counters to 0.
- Every other output to 0: img_rd_addr, conv_valid, conv_input_port, conv_bias, res_wr_en, res_wr_addr, res_wr_data, busy, done, error.

Verification
REQ-021 Single pass: bias[0]=0x10, num_passes=1, start; model emits 100 results then finish.
- conv_valid high exactly 144 contiguous cycles, pixel k matching image[k].
- 100 writes to addresses 0..99.
- done pulses once; error=0.
REQ-022 Three passes: biases 1,2,3; num_passes=3.
- conv_reset pulses 3 times.
- conv_bias is 1, 2, 3 per pass.
- Writes go to 0..299 in order; one done.
REQ-023 Short/long pass:
- Model gives 99 results then finish -> error=1, done pulses.
- Model gives 101 results -> the 101st is not written, error=1.
REQ-024 Timeout: model never asserts finish -> FIN after 1023 DRAIN cycles, error=1, no further passes.
REQ-025 Reset mid-STREAM at pixel 50 -> next cycle all outputs 0 and FSM in IDLE; a fresh start then runs cleanly from pixel 0.
REQ-026 start while busy, and bias write while busy, are both ignored; bias write in IDLE takes effect on the next job.

Source files
------------

// File: rtl/conv_seq_ctrl.sv
// Sequencer that streams an image into a convolution engine pass by pass,
// supplies the per-pass bias and collects the engine's results into memory.
module conv_seq_ctrl #(
  parameter int IMG_PIXELS = 144,
  parameter int OUT_COUNT  = 100,
  parameter int TIMEOUT    = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  num_passes,
  input  logic        bias_wr_en,
  input  logic [2:0]  bias_wr_idx,
  input  logic [31:0] bias_wr_data,
  output logic [7:0]  img_rd_addr,
  input  logic [15:0] img_rd_data,
  output logic        conv_reset,
  output logic        conv_valid,
  output logic [15:0] conv_input_port,
  output logic [31:0] conv_bias,
  input  logic [31:0] conv_output_port,
  input  logic        conv_invalid,
  input  logic        conv_finish,
  output logic        res_wr_en,
  output logic [9:0]  res_wr_addr,
  output logic [31:0] res_wr_data,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int PIX_W = $clog2(IMG_PIXELS + 1);
  localparam int RES_W = $clog2(OUT_COUNT + 1);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_PIXELS - 1);
  localparam logic [RES_W-1:0] RES_FULL = RES_W'(OUT_COUNT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, CLR, PRIME, STREAM, DRAIN, FIN} state_t;

  state_t            state, state_nxt;
  logic [31:0]       bias_bank [8];
  logic [3:0]        pass_total;
  logic [2:0]        pass;
  logic [PIX_W-1:0]  pix_cnt;
  logic [RES_W-1:0]  res_cnt;
  logic [TMO_W-1:0]  drain_cnt;
  logic [9:0]        res_addr_q;
  logic [31:0]       res_data_q;
  logic              error_q;

  logic              in_pass, result_seen, capture, overflow;
  logic              pass_end, pass_fault, last_pixel, timed_out, more_passes;
  logic [RES_W-1:0]  res_cnt_after;
  logic [9:0]        res_addr_now;

  function automatic logic [3:0] clamp_passes(input logic [3:0] n);
    if (n == 4'd0) return 4'd1;
    if (n > 4'd8)  return 4'd8;
    return n;
  endfunction

  always_comb begin
    in_pass       = (state == STREAM) || (state == DRAIN);
    result_seen   = in_pass && !conv_invalid;
    capture       = result_seen && (res_cnt < RES_FULL);
    overflow      = result_seen && (res_cnt == RES_FULL);
    res_cnt_after = res_cnt + RES_W'(capture);
    pass_end      = in_pass && conv_finish;
    // A result arriving with finish is counted before the pass is judged.
    pass_fault    = pass_end && ((res_cnt_after != RES_FULL) || (state == STREAM));
    last_pixel    = (state == STREAM) && (pix_cnt == PIX_LAST);
    timed_out     = (state == DRAIN) && !conv_finish && (drain_cnt == TMO_LAST);
    more_passes   = ({1'b0, pass} + 4'd1) < pass_total;
    res_addr_now  = 10'(int'(pass) * OUT_COUNT + int'(res_cnt));
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the default assignment up front keeps this block free of latches
  // on paths where no case arm writes state_nxt.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:          if (start) state_nxt = CLR;
      CLR:           state_nxt = PRIME;
      PRIME:         state_nxt = STREAM;
      STREAM, DRAIN: begin
        if (pass_end)        state_nxt = more_passes ? CLR : FIN;
        else if (last_pixel) state_nxt = DRAIN;
        else if (timed_out)  state_nxt = FIN;
      end
      FIN:           state_nxt = IDLE;
      default:       state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the bias bank is a handful of flops that must read as zero
      // after reset, so it is reset explicitly rather than left as RAM.
      for (int i = 0; i < 8; i++) bias_bank[i] <= '0;
      pass_total <= '0;
      pass       <= '0;
      pix_cnt    <= '0;
      res_cnt    <= '0;
      drain_cnt  <= '0;
      res_addr_q <= '0;
      res_data_q <= '0;
      error_q    <= 1'b0;
    end else begin
      if (bias_wr_en && (state == IDLE)) bias_bank[bias_wr_idx] <= bias_wr_data;
      if ((state == IDLE) && start) begin
        pass_total <= clamp_passes(num_passes);
        pass       <= '0;
        error_q    <= 1'b0;
      end
      if (state == CLR) begin
        pix_cnt   <= '0;
        res_cnt   <= '0;
        drain_cnt <= '0;
      end
      if (state == STREAM) pix_cnt <= pix_cnt + PIX_W'(1);
      if (state == DRAIN)  drain_cnt <= drain_cnt + TMO_W'(1);
      if (capture) begin
        res_cnt    <= res_cnt_after;
        res_addr_q <= res_addr_now;
        res_data_q <= conv_output_port;
      end
      if (pass_end && more_passes) pass <= pass + 3'd1;
      if (overflow || pass_fault || timed_out) error_q <= 1'b1;
    end
  end

  // Write address/data follow the capture combinationally and hold otherwise.
  always_comb begin
    conv_reset      = (state == CLR) || !reset;
    conv_valid      = (state == STREAM);
    conv_input_port = (state == STREAM) ? img_rd_data : '0;
    img_rd_addr     = (state == STREAM) ? 8'(pix_cnt) + 8'd1 : 8'd0;
    conv_bias       = (state inside {CLR, PRIME, STREAM, DRAIN}) ? bias_bank[pass] : '0;
    res_wr_en       = capture;
    res_wr_addr     = capture ? res_addr_now : res_addr_q;
    res_wr_data     = capture ? conv_output_port : res_data_q;
    busy            = (state != IDLE);
    done            = (state == FIN);
    error           = error_q;
  end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: a cycle-level conv engine and image memory model
// drive the DUT while a per-job scoreboard judges pixels, biases and results.
module tb_conv_seq_ctrl;
  localparam int IMG_PIXELS = 144;
  localparam int OUT_COUNT  = 100;
  localparam int TIMEOUT    = 1023;
  localparam int JOB_BUDGET = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  num_passes;
  logic        bias_wr_en;
  logic [2:0]  bias_wr_idx;
  logic [31:0] bias_wr_data;
  logic [7:0]  img_rd_addr;
  logic [15:0] img_rd_data;
  logic        conv_reset;
  logic        conv_valid;
  logic [15:0] conv_input_port;
  logic [31:0] conv_bias;
  logic [31:0] conv_output_port;
  logic        conv_invalid;
  logic        conv_finish;
  logic        res_wr_en;
  logic [9:0]  res_wr_addr;
  logic [31:0] res_wr_data;
  logic        busy;
  logic        done;
  logic        error;

  conv_seq_ctrl #(
    .IMG_PIXELS(IMG_PIXELS),
    .OUT_COUNT (OUT_COUNT),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .num_passes      (num_passes),
    .bias_wr_en      (bias_wr_en),
    .bias_wr_idx     (bias_wr_idx),
    .bias_wr_data    (bias_wr_data),
    .img_rd_addr     (img_rd_addr),
    .img_rd_data     (img_rd_data),
    .conv_reset      (conv_reset),
    .conv_valid      (conv_valid),
    .conv_input_port (conv_input_port),
    .conv_bias       (conv_bias),
    .conv_output_port(conv_output_port),
    .conv_invalid    (conv_invalid),
    .conv_finish     (conv_finish),
    .res_wr_en       (res_wr_en),
    .res_wr_addr     (res_wr_addr),
    .res_wr_data     (res_wr_data),
    .busy            (busy),
    .done            (done),
    .error           (error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] img_mem [256];
  logic [31:0] bias_model [8];
  logic [9:0]  last_wr_addr;
  logic [31:0] last_wr_data;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic check_quiet_outputs(input string tag, input logic exp_conv_reset);
    check({tag, "_img_rd_addr"}, img_rd_addr, 0);
    check({tag, "_conv_valid"}, conv_valid, 0);
    check({tag, "_conv_input_port"}, conv_input_port, 0);
    check({tag, "_conv_bias"}, conv_bias, 0);
    check({tag, "_res_wr_en"}, res_wr_en, 0);
    check({tag, "_res_wr_addr"}, res_wr_addr, 0);
    check({tag, "_res_wr_data"}, res_wr_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_conv_reset"}, conv_reset, exp_conv_reset);
  endtask

  task automatic write_bias(input int idx, input logic [31:0] val);
    @(negedge clk);
    bias_wr_en   = 1'b1;
    bias_wr_idx  = idx[2:0];
    bias_wr_data = val;
    @(negedge clk);
    bias_wr_en   = 1'b0;
    bias_model[idx] = val;
  endtask

  task automatic fill_image();
    for (int i = 0; i < 256; i++) img_mem[i] = 16'($urandom);
  endtask

  // One job: the engine emits 'give' results per pass starting 20 pixels in,
  // and raises finish once the stream is over and all results are out
  // (never, when no_finish is set). poke issues start and a bias write mid-job.
  task automatic run_job(input string tag, input int np_req, input int give,
                         input bit no_finish, input bit poke);
    int   n_eff, passes_exp, pass_idx, pix_seen, given;
    int   valid_cnt, runs, creset_cnt, pix_bad, addr_bad, bias_bad;
    int   wr_cnt, wr_bad, hold_bad, busy_bad, extra_done;
    int   last_valid_cyc, done_cyc, exp_writes;
    bit   fin_sent, got_done, prev_valid, err_at_done, err_exp;
    logic [7:0]  prev_addr;
    logic [31:0] data;
    wr_t  item;
    wr_t  exp_q[$];

    n_eff      = (np_req == 0) ? 1 : ((np_req > 8) ? 8 : np_req);
    passes_exp = no_finish ? 1 : n_eff;
    exp_writes = passes_exp * ((give < OUT_COUNT) ? give : OUT_COUNT);
    err_exp    = no_finish || (give != OUT_COUNT);
    pass_idx = -1; pix_seen = 0; given = 0;
    valid_cnt = 0; runs = 0; creset_cnt = 0; pix_bad = 0; addr_bad = 0; bias_bad = 0;
    wr_cnt = 0; wr_bad = 0; hold_bad = 0; busy_bad = 0; extra_done = 0;
    last_valid_cyc = -1; done_cyc = -1;
    fin_sent = 0; got_done = 0; prev_valid = 0; err_at_done = 0;

    @(negedge clk);
    num_passes = np_req[3:0];
    start      = 1'b1;
    prev_addr  = img_rd_addr;

    for (int cyc = 0; cyc < JOB_BUDGET && !got_done; cyc++) begin
      @(negedge clk);
      start      = 1'b0;
      bias_wr_en = 1'b0;
      if (poke && cyc == 40) begin
        start        = 1'b1;
        num_passes   = 4'd1;
        bias_wr_en   = 1'b1;
        bias_wr_idx  = 3'd1;
        bias_wr_data = $urandom;
      end
      img_rd_data  = img_mem[prev_addr];
      conv_invalid = 1'b1;
      conv_finish  = 1'b0;
      #1;
      if (cyc == 0) check({tag, "_error_cleared"}, error, 0);
      if (!busy) busy_bad++;
      if (conv_reset) begin
        pass_idx++;
        pix_seen = 0;
        given    = 0;
        fin_sent = 0;
        creset_cnt++;
        if (conv_bias !== bias_model[pass_idx[2:0]]) bias_bad++;
      end
      if (conv_valid) begin
        if (!prev_valid) runs++;
        valid_cnt++;
        if (pix_seen >= IMG_PIXELS || conv_input_port !== img_mem[pix_seen]) pix_bad++;
        if (img_rd_addr !== 8'(pix_seen + 1)) addr_bad++;
        if (conv_bias !== bias_model[pass_idx[2:0]]) bias_bad++;
        pix_seen++;
        last_valid_cyc = cyc;
      end
      prev_valid = conv_valid;
      if (done && conv_bias !== 32'd0) bias_bad++;

      if (pass_idx >= 0 && !fin_sent && pix_seen >= 20 && given < give &&
          $urandom_range(9) < 7) begin
        data             = $urandom;
        conv_invalid     = 1'b0;
        conv_output_port = data;
        if (given < OUT_COUNT) begin
          item.addr = 10'(pass_idx * OUT_COUNT + given);
          item.data = data;
          exp_q.push_back(item);
        end
        given++;
      end
      if (pass_idx >= 0 && !fin_sent && !no_finish && pix_seen == IMG_PIXELS &&
          !conv_valid && given == give) begin
        conv_finish = 1'b1;
        fin_sent    = 1'b1;
      end
      #1;
      if (res_wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) begin
          wr_bad++;
          last_wr_addr = res_wr_addr;
          last_wr_data = res_wr_data;
        end else begin
          item = exp_q.pop_front();
          if (res_wr_addr !== item.addr || res_wr_data !== item.data) wr_bad++;
          last_wr_addr = item.addr;
          last_wr_data = item.data;
        end
      end else if (res_wr_addr !== last_wr_addr || res_wr_data !== last_wr_data) begin
        hold_bad++;
      end
      if (done) begin
        got_done    = 1;
        done_cyc    = cyc;
        err_at_done = error;
      end
      prev_addr = img_rd_addr;
    end
    conv_invalid = 1'b1;
    conv_finish  = 1'b0;
    check({tag, "_done_seen"}, got_done, 1);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      if (done) extra_done++;
      if (i == 0) check({tag, "_busy_after"}, busy, 0);
      if (i == 2) check({tag, "_error_sticky"}, error, err_exp);
    end

    check({tag, "_extra_done"}, extra_done, 0);
    check({tag, "_conv_reset_pulses"}, creset_cnt, passes_exp);
    check({tag, "_valid_cycles"}, valid_cnt, passes_exp * IMG_PIXELS);
    check({tag, "_valid_runs"}, runs, passes_exp);
    check({tag, "_pixel_bad"}, pix_bad, 0);
    check({tag, "_rd_addr_bad"}, addr_bad, 0);
    check({tag, "_bias_bad"}, bias_bad, 0);
    check({tag, "_writes"}, wr_cnt, exp_writes);
    check({tag, "_write_bad"}, wr_bad, 0);
    check({tag, "_writes_left"}, exp_q.size(), 0);
    check({tag, "_hold_bad"}, hold_bad, 0);
    check({tag, "_busy_bad"}, busy_bad, 0);
    check({tag, "_error_at_done"}, err_at_done, err_exp);
    if (no_finish) check({tag, "_drain_len"}, done_cyc - last_valid_cyc, TIMEOUT + 1);
  endtask

  int          mid_pix;
  bit          mid_hit;
  logic [7:0]  mid_addr;
  int          np_list [3];

  initial begin
    reset            = 1'b0;
    start            = 1'b0;
    num_passes       = 4'd0;
    bias_wr_en       = 1'b0;
    bias_wr_idx      = 3'd0;
    bias_wr_data     = 32'd0;
    img_rd_data      = 16'hBEEF;
    conv_output_port = 32'd0;
    conv_invalid     = 1'b1;
    conv_finish      = 1'b0;
    last_wr_addr     = '0;
    last_wr_data     = '0;
    for (int i = 0; i < 8; i++) bias_model[i] = '0;
    fill_image();

    repeat (2) @(negedge clk);
    #1;
    check_quiet_outputs("por", 1'b1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_quiet_outputs("por_release", 1'b0);

    write_bias(0, 32'h10);
    run_job("single", 1, 100, 0, 0);

    write_bias(0, 32'd1);
    write_bias(1, 32'd2);
    write_bias(2, 32'd3);
    fill_image();
    run_job("three", 3, 100, 0, 0);

    run_job("short", 1, 99, 0, 0);
    run_job("long", 1, 101, 0, 0);
    run_job("timeout", 3, 100, 1, 0);

    write_bias(0, $urandom);
    write_bias(1, $urandom);
    run_job("busy_poke", 2, 100, 0, 1);
    write_bias(1, $urandom);
    run_job("bias_next", 2, 100, 0, 0);

    np_list[0] = 0;
    np_list[1] = 12;
    np_list[2] = int'($urandom_range(8, 1));
    for (int j = 0; j < 3; j++) begin
      for (int b = 0; b < 8; b++) write_bias(b, $urandom);
      fill_image();
      run_job($sformatf("rand%0d", j), np_list[j], 100, 0, 0);
    end

    // Reset asserted while pixel 50 of the first pass is on the bus.
    write_bias(0, 32'hA5A5_0001);
    write_bias(1, 32'hA5A5_0002);
    @(negedge clk);
    num_passes = 4'd2;
    start      = 1'b1;
    mid_addr   = img_rd_addr;
    mid_pix    = 0;
    mid_hit    = 0;
    for (int cyc = 0; cyc < 400 && !mid_hit; cyc++) begin
      @(negedge clk);
      start       = 1'b0;
      img_rd_data = img_mem[mid_addr];
      #1;
      if (conv_valid) begin
        if (mid_pix == 50) begin
          mid_hit = 1;
          reset   = 1'b0;
        end
        mid_pix++;
      end
      mid_addr = img_rd_addr;
    end
    check("mid_reset_reached", mid_hit, 1);
    @(negedge clk);
    #1;
    check_quiet_outputs("mid_reset", 1'b1);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) bias_model[i] = '0;
    last_wr_addr = '0;
    last_wr_data = '0;
    @(negedge clk);
    #1;
    check_quiet_outputs("mid_reset_release", 1'b0);
    run_job("after_reset", 1, 100, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
